store_buffer: RTL and testbench

Memory-stage store writer: the write-side counterpart of the writeback load-extension path. It accepts store requests (address, data, size) from the pipeline. It places byte/halfword data onto the correct lanes and generates byte enables, then buffers the stores in a small FIFO. The FIFO drains to data memory over a req/ack handshake. It also flags loads that hit a pending store word so the pipeline can stall until the store drains.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_align.sv | 33 +++
 rtl/store_buffer.sv | 124 ++++++++++++
 tb/tb_store_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store/load size encodings, byte-enable constants and the store FIFO entry layout.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        SZ_WORD     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_BYTE     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } st_size_e;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Places store data on its byte lanes, builds byte enables and flags misaligned accesses.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] al_data,
    output logic [3:0]  al_be,
    output logic        misalign
);

    always_comb begin
        al_data  = data;
        al_be    = BE_ALL;
        misalign = 1'b0;
        case (st_size_e'(size))
            SZ_BYTE: begin
                al_data = {4{data[7:0]}};
                al_be   = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                al_data  = {2{data[15:0]}};
                al_be    = addr_lo[1] ? BE_HI : BE_LO;
                misalign = addr_lo[0];
            end
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between the MEM stage and data memory: lane alignment, req/ack drain and load-hit detection.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ST_inVALID,
    input  logic [31:0] ST_inADDR,
    input  logic [31:0] ST_inDATA,
    input  logic [1:0]  ST_inSIZE,
    output logic        ST_outREADY,
    output logic        ST_outMISALIGN,
    output logic        ST_outEMPTY,
    output logic        ST_outMEMREQ,
    output logic [31:0] ST_outMEMADDR,
    output logic [31:0] ST_outMEMDATA,
    output logic [3:0]  ST_outMEMBE,
    input  logic        ST_inMEMACK,
    input  logic        ST_inLDVALID,
    input  logic [31:0] ST_inLDADDR,
    output logic        ST_outLDHIT
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             misalign_q, misalign_d;
    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        ent_d [DEPTH];

    logic [31:0] al_data;
    logic [3:0]  al_be;
    logic        al_mis;
    logic        ready, empty, accept, push, pop, ld_match;
    sb_entry_t   head;

    store_align u_align (
        .addr_lo  (ST_inADDR[1:0]),
        .size     (ST_inSIZE),
        .data     (ST_inDATA),
        .al_data  (al_data),
        .al_be    (al_be),
        .misalign (al_mis)
    );

    assign ready  = (count_q < FULL_COUNT);
    assign empty  = (count_q == '0);
    assign accept = ST_inVALID && ready;
    assign push   = accept && !al_mis;
    assign pop    = !empty && ST_inMEMACK;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        misalign_d = accept && al_mis;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        // Pop and push never target the same slot: push needs a non-full FIFO, pop a non-empty one.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push) begin
            ent_d[wr_ptr_q]   = '{waddr: ST_inADDR[31:2], data: al_data, be: al_be};
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Payload needs no reset: outputs are masked while empty and valid_q gates the hit compare.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_comb begin
        ld_match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (ent_q[i].waddr == ST_inLDADDR[31:2])) begin
                ld_match = 1'b1;
            end
        end
    end

    assign head           = ent_q[rd_ptr_q];
    assign ST_outREADY    = ready;
    assign ST_outEMPTY    = empty;
    assign ST_outMEMREQ   = !empty;
    assign ST_outMEMADDR  = empty ? '0 : {head.waddr, 2'b00};
    assign ST_outMEMDATA  = empty ? '0 : head.data;
    assign ST_outMEMBE    = empty ? '0 : head.be;
    assign ST_outMISALIGN = misalign_q;
    assign ST_outLDHIT    = ST_inLDVALID && ld_match;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: cycle table plus backpressure, reset and wrap sequences.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        ready, misalign, empty, memreq;
    logic [31:0] memaddr, memdata;
    logic [3:0]  membe;
    logic        memack;
    logic        ldvalid;
    logic [31:0] ldaddr;
    logic        ldhit;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ST_inVALID     (st_valid),
        .ST_inADDR      (st_addr),
        .ST_inDATA      (st_data),
        .ST_inSIZE      (st_size),
        .ST_outREADY    (ready),
        .ST_outMISALIGN (misalign),
        .ST_outEMPTY    (empty),
        .ST_outMEMREQ   (memreq),
        .ST_outMEMADDR  (memaddr),
        .ST_outMEMDATA  (memdata),
        .ST_outMEMBE    (membe),
        .ST_inMEMACK    (memack),
        .ST_inLDVALID   (ldvalid),
        .ST_inLDADDR    (ldaddr),
        .ST_outLDHIT    (ldhit)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        ack;
        logic        ldv;
        logic [31:0] ldaddr;
        logic        e_ready;
        logic        e_empty;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic        e_mis;
        logic        e_hit;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic ack, input logic lv, input logic [31:0] la);
        st_valid = v; st_addr = a; st_data = d; st_size = s;
        memack = ack; ldvalid = lv; ldaddr = la;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        chk({nm, "_req"}, {31'd0, memreq}, 32'd1);
        chk({nm, "_addr"}, memaddr, a);
        chk({nm, "_data"}, memdata, d);
        chk({nm, "_be"}, {28'd0, membe}, {28'd0, be});
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_empty"}, {31'd0, empty}, 32'd1);
        chk({nm, "_ready"}, {31'd0, ready}, 32'd1);
        chk({nm, "_req"}, {31'd0, memreq}, 32'd0);
        chk({nm, "_addr"}, memaddr, 32'd0);
        chk({nm, "_data"}, memdata, 32'd0);
        chk({nm, "_be"}, {28'd0, membe}, 32'd0);
    endtask

    initial begin
        // name, valid, addr, data, size, ack, ldv, ldaddr | ready, empty, req, addr, data, be, mis, hit
        vecs.push_back('{"reset",      0, 32'h0,    32'h0,        2'd0, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"byte_acc",   1, 32'h1003, 32'h000000AB, 2'd2, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"byte_head",  0, 32'h0,    32'h0,        2'd0, 0, 1, 32'h1000, 1, 0, 1, 32'h1000, 32'hABABABAB, 4'h8, 0, 1});
        vecs.push_back('{"byte_pop",   0, 32'h0,    32'h0,        2'd0, 1, 1, 32'h1004, 1, 0, 1, 32'h1000, 32'hABABABAB, 4'h8, 0, 0});
        vecs.push_back('{"half_acc",   1, 32'h2002, 32'h12345678, 2'd1, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"half_mis",   1, 32'h2001, 32'h12345678, 2'd1, 0, 0, 32'h0,    1, 0, 1, 32'h2000, 32'h56785678, 4'hC, 0, 0});
        vecs.push_back('{"mis_pulse",  0, 32'h0,    32'h0,        2'd0, 1, 0, 32'h0,    1, 0, 1, 32'h2000, 32'h56785678, 4'hC, 1, 0});
        vecs.push_back('{"mis_gone",   0, 32'h0,    32'h0,        2'd0, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"ld_acc",     1, 32'h3004, 32'h0000005A, 2'd2, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"ld_hit",     0, 32'h0,    32'h0,        2'd0, 0, 1, 32'h3007, 1, 0, 1, 32'h3004, 32'h5A5A5A5A, 4'h1, 0, 1});
        vecs.push_back('{"ld_miss",    0, 32'h0,    32'h0,        2'd0, 0, 1, 32'h3008, 1, 0, 1, 32'h3004, 32'h5A5A5A5A, 4'h1, 0, 0});
        vecs.push_back('{"ld_pophit",  0, 32'h0,    32'h0,        2'd0, 1, 1, 32'h3007, 1, 0, 1, 32'h3004, 32'h5A5A5A5A, 4'h1, 0, 1});
        vecs.push_back('{"ld_enq_nc",  1, 32'h3004, 32'hDEADBEEF, 2'd0, 0, 1, 32'h3007, 1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"word_head",  0, 32'h0,    32'h0,        2'd0, 0, 1, 32'h3004, 1, 0, 1, 32'h3004, 32'hDEADBEEF, 4'hF, 0, 1});
        vecs.push_back('{"word_pop",   0, 32'h0,    32'h0,        2'd0, 1, 0, 32'h0,    1, 0, 1, 32'h3004, 32'hDEADBEEF, 4'hF, 0, 0});
        vecs.push_back('{"ack_empty",  0, 32'h0,    32'h0,        2'd0, 1, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"sz11_acc",   1, 32'h4000, 32'hCAFEF00D, 2'd3, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"sz11_head",  0, 32'h0,    32'h0,        2'd0, 1, 0, 32'h0,    1, 0, 1, 32'h4000, 32'hCAFEF00D, 4'hF, 0, 0});
        vecs.push_back('{"sz11_mis",   1, 32'h4002, 32'h00000001, 2'd3, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"sz11_pulse", 0, 32'h0,    32'h0,        2'd0, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 1, 0});
        vecs.push_back('{"byte_l0",    1, 32'h7000, 32'h11223344, 2'd2, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"byte_l0_h",  0, 32'h0,    32'h0,        2'd0, 1, 0, 32'h0,    1, 0, 1, 32'h7000, 32'h44444444, 4'h1, 0, 0});
        vecs.push_back('{"half_lo",    1, 32'h7000, 32'hFFFF8001, 2'd1, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"half_lo_h",  0, 32'h0,    32'h0,        2'd0, 1, 0, 32'h0,    1, 0, 1, 32'h7000, 32'h80018001, 4'h3, 0, 0});
        vecs.push_back('{"byte_l2",    1, 32'h7006, 32'h000000C3, 2'd2, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});
        vecs.push_back('{"byte_l2_h",  0, 32'h0,    32'h0,        2'd0, 1, 0, 32'h0,    1, 0, 1, 32'h7004, 32'hC3C3C3C3, 4'h4, 0, 0});
        vecs.push_back('{"drained",    0, 32'h0,    32'h0,        2'd0, 0, 0, 32'h0,    1, 1, 0, 32'h0,    32'h0,        4'h0, 0, 0});

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].valid, vecs[k].addr, vecs[k].data, vecs[k].size,
                  vecs[k].ack, vecs[k].ldv, vecs[k].ldaddr);
            #1;
            chk({vecs[k].name, "_ready"}, {31'd0, ready},    {31'd0, vecs[k].e_ready});
            chk({vecs[k].name, "_empty"}, {31'd0, empty},    {31'd0, vecs[k].e_empty});
            chk({vecs[k].name, "_req"},   {31'd0, memreq},   {31'd0, vecs[k].e_req});
            chk({vecs[k].name, "_addr"},  memaddr,           vecs[k].e_addr);
            chk({vecs[k].name, "_data"},  memdata,           vecs[k].e_data);
            chk({vecs[k].name, "_be"},    {28'd0, membe},    {28'd0, vecs[k].e_be});
            chk({vecs[k].name, "_mis"},   {31'd0, misalign}, {31'd0, vecs[k].e_mis});
            chk({vecs[k].name, "_hit"},   {31'd0, ldhit},    {31'd0, vecs[k].e_hit});
            @(posedge clk);
            #1;
        end

        // Backpressure: four words fill the FIFO, the fifth is held until the first pop.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h5000 + 32'(4 * i), 32'h1000 + 32'(i), 2'd0, 0, 0, 0);
            #1;
            chk("bp_fill_ready", {31'd0, ready}, 32'd1);
            next_cycle();
        end
        drive(1, 32'h5010, 32'h1004, 2'd0, 0, 0, 0);
        #1;
        chk("bp_full_ready", {31'd0, ready}, 32'd0);
        chk_head("bp_full", 32'h5000, 32'h1000, 4'hF);
        next_cycle();
        chk("bp_hold_ready", {31'd0, ready}, 32'd0);
        memack = 1'b1;
        #1;
        chk("bp_ack_ready", {31'd0, ready}, 32'd0);
        chk_head("bp_ack", 32'h5000, 32'h1000, 4'hF);
        next_cycle();
        chk("bp_after_pop_ready", {31'd0, ready}, 32'd1);
        chk_head("bp_d1", 32'h5004, 32'h1001, 4'hF);
        next_cycle();
        st_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            #1;
            chk_head("bp_drain", 32'h5000 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
            next_cycle();
        end
        memack = 1'b0;
        #1;
        chk_idle("bp_done");
        next_cycle();

        // Reset with three entries pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h8000 + 32'(4 * i), 32'h2000 + 32'(i), 2'd0, 0, 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 1, 32'h8004);
        #1;
        chk("rst_pre_req", {31'd0, memreq}, 32'd1);
        chk("rst_pre_hit", {31'd0, ldhit}, 32'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        chk_idle("rst_post");
        chk("rst_post_hit", {31'd0, ldhit}, 32'd0);
        ldvalid = 1'b0;
        next_cycle();

        // Simultaneous push and pop at count 2 across several pointer wraps.
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h9000 + 32'(4 * i), 32'h3000 + 32'(i), 2'd0, 0, 0, 0);
            next_cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h9000 + 32'(4 * (k + 2)), 32'h3000 + 32'(k + 2), 2'd0, 1, 0, 0);
            #1;
            chk("wrap_ready", {31'd0, ready}, 32'd1);
            chk("wrap_empty", {31'd0, empty}, 32'd0);
            chk_head("wrap", 32'h9000 + 32'(4 * k), 32'h3000 + 32'(k), 4'hF);
            next_cycle();
        end
        st_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            #1;
            chk_head("wrap_tail", 32'h9000 + 32'(4 * k), 32'h3000 + 32'(k), 4'hF);
            next_cycle();
        end
        memack = 1'b0;
        #1;
        chk_idle("wrap_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
